init_reg_readback_checker: RTL and testbench

- APB requester that walks the system-initialization table after the init writer has run.
- Issues one APB read per table entry and compares the returned data against the expected 32b data.
- Reports pass/fail, an error count and first-failure details to the bring-up status registers.
- Sits on the APB clock domain, muxed onto the same APB bus as the init writer; the two are never active together.

---
 rtl/init_reg_readback_checker.sv | 139 +++++++++++++
 tb/tb_init_reg_readback_checker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/init_reg_readback_checker.sv
// APB read-back checker: reads every init-table entry and compares it with the expected data.
// Optional INIT_RB_SKIP_EN adds i_skip_mask to bypass self-clearing entries without a transfer.
module init_reg_readback_checker #(
  parameter int N_ENTRY        = 22,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDX_W          = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1
) (
  input  logic             i_apb_clk,
  input  logic             i_apb_rst,
  input  logic             i_start,
  output logic [IDX_W-1:0] o_tbl_idx,
  input  logic [63:0]      i_tbl_entry,
  output logic             o_psel,
  output logic             o_penable,
  output logic             o_pwrite,
  output logic [31:0]      o_paddr,
  input  logic [31:0]      i_prdata,
  input  logic             i_pready,
  input  logic             i_pslverr,
`ifdef INIT_RB_SKIP_EN
  input  logic [N_ENTRY-1:0] i_skip_mask,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [7:0]       o_err_cnt,
  output logic [IDX_W-1:0] o_first_err_idx,
  output logic [31:0]      o_first_err_rdata
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, FETCH, SETUP, ACCESS, CHECK, DONE} state_t;

  state_t          state, state_n;
  logic [31:0]     exp_data;
  logic [31:0]     rdata_q;
  logic            slverr_q;
  logic            timeout_q;
  logic [TO_W-1:0] to_cnt;
  logic            last;
  logic            to_hit;
  logic            fail;
  logic            skip;
  logic [7:0]      err_cnt_n;

`ifdef INIT_RB_SKIP_EN
  assign skip = i_skip_mask[o_tbl_idx];
`else
  assign skip = 1'b0;
`endif

  assign last   = (o_tbl_idx == IDX_W'(N_ENTRY - 1));
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign fail   = slverr_q | timeout_q | (rdata_q != exp_data);

  assign o_psel    = (state == SETUP) || (state == ACCESS);
  assign o_penable = (state == ACCESS);
  assign o_pwrite  = 1'b0;
  assign o_busy    = (state != IDLE) && (state != DONE);
  assign o_done    = (state == DONE);

  always_comb begin
    state_n   = state;
    err_cnt_n = o_err_cnt;
    case (state)
      IDLE:   if (i_start) state_n = FETCH;
      // A skipped entry is settled inside FETCH so it costs a single cycle.
      FETCH:  state_n = skip ? (last ? DONE : FETCH) : SETUP;
      SETUP:  state_n = ACCESS;
      ACCESS: if (i_pready || to_hit) state_n = CHECK;
      CHECK: begin
        state_n = last ? DONE : FETCH;
        if (fail && (o_err_cnt != 8'hFF)) err_cnt_n = o_err_cnt + 8'd1;
      end
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_apb_clk) begin
    if (i_apb_rst) begin
      state             <= IDLE;
      o_tbl_idx         <= '0;
      o_paddr           <= '0;
      exp_data          <= '0;
      rdata_q           <= '0;
      slverr_q          <= 1'b0;
      timeout_q         <= 1'b0;
      to_cnt            <= '0;
      o_pass            <= 1'b0;
      o_err_cnt         <= '0;
      o_first_err_idx   <= '0;
      o_first_err_rdata <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (i_start) begin
          o_tbl_idx         <= '0;
          o_pass            <= 1'b0;
          o_err_cnt         <= '0;
          o_first_err_idx   <= '0;
          o_first_err_rdata <= '0;
        end
        FETCH: begin
          o_paddr  <= i_tbl_entry[63:32];
          exp_data <= i_tbl_entry[31:0];
          if (skip && !last) o_tbl_idx <= o_tbl_idx + IDX_W'(1);
        end
        SETUP: to_cnt <= '0;
        ACCESS: begin
          if (i_pready) begin
            rdata_q   <= i_prdata;
            slverr_q  <= i_pslverr;
            timeout_q <= 1'b0;
          end else if (to_hit) begin
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        CHECK: begin
          o_err_cnt <= err_cnt_n;
          if (fail && (o_err_cnt == 8'd0)) begin
            o_first_err_idx   <= o_tbl_idx;
            o_first_err_rdata <= rdata_q;
          end
          if (!last) o_tbl_idx <= o_tbl_idx + IDX_W'(1);
        end
        default: ;
      endcase
      // Pass verdict lands together with o_done.
      if (state_n == DONE && state != DONE) o_pass <= (err_cnt_n == 8'd0);
    end
  end

endmodule

// File: tb/tb_init_reg_readback_checker.sv
// Directed bench for init_reg_readback_checker: behavioural APB slave plus per-scenario tasks.
module tb_init_reg_readback_checker;

  localparam int N  = 22;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [IW-1:0] o_tbl_idx;
  logic [63:0]   i_tbl_entry;
  logic          o_psel, o_penable, o_pwrite;
  logic [31:0]   o_paddr;
  logic [31:0]   i_prdata;
  logic          i_pready, i_pslverr;
  logic          o_busy, o_done, o_pass;
  logic [7:0]    o_err_cnt;
  logic [IW-1:0] o_first_err_idx;
  logic [31:0]   o_first_err_rdata;
`ifdef INIT_RB_SKIP_EN
  logic [N-1:0]  skip_mask = '0;
`endif

  logic [31:0] tbl_addr [N];
  logic [31:0] tbl_data [N];
  logic [N-1:0] bad_mask = '0;
  int slverr_idx = -1;
  int hang_idx   = -1;
  int wait_states = 0;
  int ws_cnt = 0;
  int cur_idx;
  int hang_acc = 0;
  int viol = 0;
  logic [31:0] setup_addr = '0;
  logic [31:0] rd_log [$];
  logic [7:0] err_after_start;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  init_reg_readback_checker #(.N_ENTRY(N), .TIMEOUT_CYCLES(8)) dut (
    .i_apb_clk(clk), .i_apb_rst(rst), .i_start(i_start),
    .o_tbl_idx(o_tbl_idx), .i_tbl_entry(i_tbl_entry),
    .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite), .o_paddr(o_paddr),
    .i_prdata(i_prdata), .i_pready(i_pready), .i_pslverr(i_pslverr),
`ifdef INIT_RB_SKIP_EN
    .i_skip_mask(skip_mask),
`endif
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_err_cnt(o_err_cnt),
    .o_first_err_idx(o_first_err_idx), .o_first_err_rdata(o_first_err_rdata)
  );

  assign i_tbl_entry = {tbl_addr[o_tbl_idx], tbl_data[o_tbl_idx]};

  // Slave decodes the address back to a table entry and injects the configured faults.
  always_comb begin
    cur_idx = -1;
    for (int i = 0; i < N; i++) if (tbl_addr[i] == o_paddr) cur_idx = i;
  end

  always_comb begin
    i_prdata  = 32'hDEAD_BEEF;
    i_pslverr = 1'b0;
    if (cur_idx >= 0) begin
      i_prdata  = tbl_data[cur_idx] ^ (bad_mask[cur_idx] ? 32'h1 : 32'h0);
      i_pslverr = (cur_idx == slverr_idx);
    end
  end

  assign i_pready = o_psel && o_penable && (ws_cnt >= wait_states) && (cur_idx != hang_idx);

  always @(posedge clk) begin
    if (o_psel && o_penable && !i_pready) ws_cnt <= ws_cnt + 1;
    else ws_cnt <= 0;
  end

  always @(negedge clk) begin
    if (o_pwrite) viol++;
    if (o_psel && !o_penable) setup_addr = o_paddr;
    if (o_psel && o_penable) begin
      if (o_paddr != setup_addr) viol++;
      if (hang_idx >= 0 && cur_idx == hang_idx) hang_acc++;
      if (i_pready) rd_log.push_back(o_paddr);
    end
  end

  task automatic run_pass(input int extra_start_at, output int cyc);
    bit got;
    got = 0;
    rd_log.delete();
    hang_acc = 0;
    @(negedge clk);
    i_start = 1'b1;
    cyc = 0;
    while (cyc < 2000 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) err_after_start = o_err_cnt;
      if (o_done) got = 1;
      else i_start = (cyc == extra_start_at);
    end
    i_start = 1'b0;
    if (!got) cyc = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({o_psel, o_penable, o_pwrite} !== 3'b000) begin n_fail++; $display("FAIL reset_apb: got %b exp 000", {o_psel, o_penable, o_pwrite}); end
    n_checks++; if ({o_busy, o_done, o_pass} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b exp 000", {o_busy, o_done, o_pass}); end
    n_checks++; if (o_err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d exp 0", o_err_cnt); end
    n_checks++; if ({o_tbl_idx, o_first_err_idx} !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d/%0d exp 0/0", o_tbl_idx, o_first_err_idx); end
    n_checks++; if ({o_paddr, o_first_err_rdata} !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h/%h exp 0/0", o_paddr, o_first_err_rdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_pass;
    int cyc;
    int ord_err;
    run_pass(0, cyc);
    n_checks++; if (cyc !== 89) begin n_fail++; $display("FAIL all_pass_done_cycle: got %0d exp 89", cyc); end
    n_checks++; if ({o_pass, o_err_cnt} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL all_pass_status: got pass=%b err=%0d exp pass=1 err=0", o_pass, o_err_cnt); end
    n_checks++; if (rd_log.size() !== N) begin n_fail++; $display("FAIL all_pass_reads: got %0d exp %0d", rd_log.size(), N); end
    ord_err = 0;
    for (int i = 0; i < N && i < rd_log.size(); i++) if (rd_log[i] !== tbl_addr[i]) ord_err++;
    n_checks++; if (ord_err !== 0 || rd_log.size() == 0 || rd_log[0] !== 32'h1000_7A74) begin n_fail++; $display("FAIL all_pass_order: %0d out of order entries, first addr required 10007a74", ord_err); end
    @(negedge clk);
    n_checks++; if ({o_done, o_busy, o_pass} !== 3'b001) begin n_fail++; $display("FAIL all_pass_after_done: got done/busy/pass=%b exp 001", {o_done, o_busy, o_pass}); end
  endtask

  task automatic test_mismatch;
    int cyc;
    bad_mask = '0;
    bad_mask[6] = 1'b1;
    run_pass(0, cyc);
    n_checks++; if (o_err_cnt !== 8'd1) begin n_fail++; $display("FAIL mismatch_err_cnt: got %0d exp 1", o_err_cnt); end
    n_checks++; if (o_first_err_idx !== 5'd6) begin n_fail++; $display("FAIL mismatch_first_idx: got %0d exp 6", o_first_err_idx); end
    n_checks++; if (o_first_err_rdata !== 32'h0000_0002) begin n_fail++; $display("FAIL mismatch_first_rdata: got %h exp 00000002", o_first_err_rdata); end
    n_checks++; if (o_pass !== 1'b0) begin n_fail++; $display("FAIL mismatch_pass: got %b exp 0", o_pass); end
    bad_mask = '0;
  endtask

  task automatic test_slverr;
    int cyc;
    slverr_idx = 0;
    bad_mask[10] = 1'b1;
    run_pass(0, cyc);
    n_checks++; if (o_err_cnt !== 8'd2) begin n_fail++; $display("FAIL slverr_err_cnt: got %0d exp 2", o_err_cnt); end
    n_checks++; if (o_first_err_idx !== 5'd0) begin n_fail++; $display("FAIL slverr_first_idx: got %0d exp 0", o_first_err_idx); end
    n_checks++; if (o_first_err_rdata !== tbl_data[0]) begin n_fail++; $display("FAIL slverr_first_rdata: got %h exp %h", o_first_err_rdata, tbl_data[0]); end
    n_checks++; if (rd_log.size() !== N) begin n_fail++; $display("FAIL slverr_reads: got %0d exp %0d", rd_log.size(), N); end
    slverr_idx = -1;
    bad_mask = '0;
  endtask

  task automatic test_timeout;
    int cyc;
    hang_idx = 3;
    run_pass(0, cyc);
    n_checks++; if (hang_acc !== 8) begin n_fail++; $display("FAIL timeout_access_len: got %0d exp 8", hang_acc); end
    n_checks++; if (o_first_err_idx !== 5'd3) begin n_fail++; $display("FAIL timeout_first_idx: got %0d exp 3", o_first_err_idx); end
    n_checks++; if (o_first_err_rdata !== 32'd0) begin n_fail++; $display("FAIL timeout_first_rdata: got %h exp 0", o_first_err_rdata); end
    n_checks++; if (o_err_cnt !== 8'd1) begin n_fail++; $display("FAIL timeout_err_cnt: got %0d exp 1", o_err_cnt); end
    n_checks++; if (rd_log.size() !== N - 1 || rd_log[rd_log.size()-1] !== tbl_addr[N-1]) begin n_fail++; $display("FAIL timeout_continue: got %0d reads exp %0d ending at %h", rd_log.size(), N - 1, tbl_addr[N-1]); end
    n_checks++; if (cyc !== 89 + 7) begin n_fail++; $display("FAIL timeout_done_cycle: got %0d exp %0d", cyc, 89 + 7); end
    hang_idx = -1;
  endtask

  task automatic test_back_to_back;
    int cyc;
    wait_states = 3;
    bad_mask[6] = 1'b1;
    run_pass(20, cyc);
    n_checks++; if (cyc !== 4*22 + 3*22 + 1) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d exp %0d", cyc, 4*22 + 3*22 + 1); end
    n_checks++; if (o_err_cnt !== 8'd1) begin n_fail++; $display("FAIL b2b_err_cnt: got %0d exp 1", o_err_cnt); end
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    n_checks++; if ({o_busy, o_psel} !== 2'b00) begin n_fail++; $display("FAIL start_in_done: got busy/psel=%b exp 00", {o_busy, o_psel}); end
    bad_mask = '0;
    run_pass(0, cyc);
    n_checks++; if (err_after_start !== 8'd0) begin n_fail++; $display("FAIL b2b_err_cleared: got %0d exp 0", err_after_start); end
    n_checks++; if ({o_pass, o_err_cnt} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL b2b_second_pass: got pass=%b err=%0d exp pass=1 err=0", o_pass, o_err_cnt); end
    wait_states = 0;
  endtask

  task automatic test_reset_midpass;
    int cyc;
    int n;
    bit saw_done;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (!(o_psel && o_penable) && n < 20) begin @(negedge clk); n++; end
    n_checks++; if (!(o_psel && o_penable)) begin n_fail++; $display("FAIL midrst_reach_access: got psel/penable=%b exp 11", {o_psel, o_penable}); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({o_psel, o_penable} !== 2'b00) begin n_fail++; $display("FAIL midrst_apb_drop: got %b exp 00", {o_psel, o_penable}); end
    rst = 1'b0;
    saw_done = 0;
    repeat (150) begin @(negedge clk); if (o_done) saw_done = 1; end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got %b exp 0", saw_done); end
    run_pass(0, cyc);
    n_checks++; if (cyc !== 89 || o_pass !== 1'b1 || rd_log.size() !== N) begin n_fail++; $display("FAIL midrst_clean_pass: got cyc=%0d pass=%b reads=%0d exp 89/1/%0d", cyc, o_pass, rd_log.size(), N); end
  endtask

`ifdef INIT_RB_SKIP_EN
  task automatic test_skip;
    int cyc;
    int hits;
    skip_mask = '0;
    skip_mask[5] = 1'b1;
    skip_mask[16] = 1'b1;
    bad_mask = skip_mask;
    run_pass(0, cyc);
    hits = 0;
    foreach (rd_log[i]) if (rd_log[i] == 32'h1000_7A80 || rd_log[i] == 32'h3000_0880) hits++;
    n_checks++; if (hits !== 0) begin n_fail++; $display("FAIL skip_no_transfer: got %0d exp 0", hits); end
    n_checks++; if ({o_pass, o_err_cnt} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL skip_pass: got pass=%b err=%0d exp 1/0", o_pass, o_err_cnt); end
    n_checks++; if (cyc !== 89 - 6) begin n_fail++; $display("FAIL skip_done_cycle: got %0d exp %0d", cyc, 89 - 6); end
    skip_mask = '0;
    bad_mask = '0;
  endtask
`endif

  initial begin
    tbl_addr = '{32'h1000_7A74, 32'h1000_7A78, 32'h1000_7A7C, 32'h1000_7A70, 32'h1000_7A84,
                 32'h1000_7A80, 32'h2000_0000, 32'h2000_0004, 32'h2000_0008, 32'h2000_0010,
                 32'h2000_0100, 32'h2000_0104, 32'h3000_0800, 32'h3000_0804, 32'h3000_0808,
                 32'h3000_080C, 32'h3000_0880, 32'h3000_0884, 32'h4000_0000, 32'h4000_0004,
                 32'h4000_0040, 32'h4000_0044};
    for (int i = 0; i < N; i++) tbl_data[i] = 32'hA500_0000 | (i * 17);
    tbl_data[6] = 32'h0000_0003;
    test_reset();
    test_all_pass();
    test_mismatch();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_midpass();
`ifdef INIT_RB_SKIP_EN
    test_skip();
`endif
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL apb_protocol: got %0d violations exp 0", viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
